// File: rtl/wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
//   raddr_t          5-bit architectural register index
//   wb_gnt_t         writeback grant: none / EXEC / load response
//   WB_LD_DEPTH_DEF  default depth of the outstanding-load tag queue
package wb_arbiter_pkg;
  typedef logic [4:0] raddr_t;
  typedef enum logic [1:0] {WB_GNT_NONE, WB_GNT_EX, WB_GNT_LD} wb_gnt_t;
  localparam int WB_LD_DEPTH_DEF = 4;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle between EXEC/LSU, the arbiter and the register file.
//   slave  : the arbiter's view (takes requests, drives grants/RF write/scoreboard)
//   master : the environment's view (EXEC, LSU, DEC/RF)
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;
  logic        ex_valid_i;
  raddr_t      ex_rd_addr_i;
  logic [31:0] ex_rd_data_i;
  logic        ex_ready_o;
  logic        ld_issue_i;
  raddr_t      ld_issue_rd_i;
  logic        ld_full_o;
  logic        ld_rsp_valid_i;
  logic [31:0] ld_rsp_data_i;
  logic        ld_rsp_ready_o;
  logic        rf_we_o;
  raddr_t      rf_addr_o;
  logic [31:0] rf_data_o;
  logic [31:0] sb_pending_o;

  modport slave (
    input  ex_valid_i, ex_rd_addr_i, ex_rd_data_i, ld_issue_i, ld_issue_rd_i,
           ld_rsp_valid_i, ld_rsp_data_i,
    output ex_ready_o, ld_full_o, ld_rsp_ready_o, rf_we_o, rf_addr_o, rf_data_o,
           sb_pending_o
  );

  modport master (
    output ex_valid_i, ex_rd_addr_i, ex_rd_data_i, ld_issue_i, ld_issue_rd_i,
           ld_rsp_valid_i, ld_rsp_data_i,
    input  ex_ready_o, ld_full_o, ld_rsp_ready_o, rf_we_o, rf_addr_o, rf_data_o,
           sb_pending_o
  );
endinterface

// File: rtl/wb_ld_tag_fifo.sv
// In-order queue of destination-register tags for outstanding loads.
//   clk, rst   clock, synchronous active-high reset
//   push/tag   enqueue a tag (ignored when full unless popping the same cycle)
//   pop        dequeue the head tag
//   head_tag   tag at the read pointer
//   full/empty occupancy flags (from the registered count)
//   ent_vld    per-slot valid bits; tags = raw slot storage (scoreboard source)
module wb_ld_tag_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_LD_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  raddr_t                 push_tag,
  input  logic                   pop,
  output raddr_t                 head_tag,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH-1:0]       ent_vld,
  output raddr_t [DEPTH-1:0]     tags
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  raddr_t [DEPTH-1:0] mem;
  logic [PW-1:0]      rptr, wptr;
  logic [CW-1:0]      cnt;
  logic [DEPTH-1:0]   vld_n;
  logic               push_ok, pop_ok;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  // Full + pop frees the head slot this same edge, so the push may land.
  assign push_ok  = push && (!full || pop);
  assign pop_ok   = pop && !empty;
  assign head_tag = mem[rptr];
  assign tags     = mem;

  // When full, wptr == rptr: the clear from the pop must lose to the set
  // from the push, hence set applied last.
  always_comb begin
    vld_n = ent_vld;
    if (pop_ok)  vld_n[rptr] = 1'b0;
    if (push_ok) vld_n[wptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr    <= '0;
      wptr    <= '0;
      cnt     <= '0;
      ent_vld <= '0;
    end else begin
      ent_vld <= vld_n;
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Tag storage needs no reset: slots are qualified by ent_vld.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_tag;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop))
    else $error("load issued while tag queue full");
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between EXEC writeback and LSU load
// responses, with an in-order tag queue and a pending-load scoreboard.
//   clk, rst      clock, synchronous active-high reset
//   bus (slave)   EXEC request, LSU issue/response, RF write port, scoreboard
// Optional: define WB_STARVE_GUARD_EN to let EXEC win after MAX_LD_STREAK
// consecutive load grants made while it was waiting.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int LD_DEPTH      = WB_LD_DEPTH_DEF,
  parameter int MAX_LD_STREAK = 3
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  if (LD_DEPTH < 2 || (LD_DEPTH & (LD_DEPTH - 1)) != 0 || MAX_LD_STREAK < 1) begin : g_bad_cfg
    $error("wb_arbiter: LD_DEPTH must be a power of two >= 2, MAX_LD_STREAK >= 1");
  end

  raddr_t                head_tag;
  logic                  q_full, q_empty;
  logic [LD_DEPTH-1:0]   ent_vld;
  raddr_t [LD_DEPTH-1:0] tags;
  wb_gnt_t               gnt;
  logic                  ld_can, force_ex;
  logic [31:0]           sb;
  raddr_t                addr;
  logic [31:0]           data;

  wb_ld_tag_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.ld_issue_i),
    .push_tag (bus.ld_issue_rd_i),
    .pop      (gnt == WB_GNT_LD),
    .head_tag (head_tag),
    .full     (q_full),
    .empty    (q_empty),
    .ent_vld  (ent_vld),
    .tags     (tags)
  );

  assign ld_can = bus.ld_rsp_valid_i && !q_empty;

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_LD_STREAK + 1);
  logic [SW-1:0] streak;

  assign force_ex = bus.ex_valid_i && (streak == SW'(MAX_LD_STREAK));

  always_ff @(posedge clk) begin
    if (rst)                                    streak <= '0;
    else if (!bus.ex_valid_i || gnt == WB_GNT_EX) streak <= '0;
    else if (gnt == WB_GNT_LD)                  streak <= streak + 1'b1;
  end
`else
  assign force_ex = 1'b0;
`endif

  always_comb begin
    gnt = WB_GNT_NONE;
    if (!rst) begin
      if (ld_can && !force_ex)  gnt = WB_GNT_LD;
      else if (bus.ex_valid_i)  gnt = WB_GNT_EX;
    end
  end

  always_comb begin
    addr = '0;
    data = '0;
    case (gnt)
      WB_GNT_LD: begin addr = head_tag;         data = bus.ld_rsp_data_i; end
      WB_GNT_EX: begin addr = bus.ex_rd_addr_i; data = bus.ex_rd_data_i;  end
      default: ;
    endcase
  end

  // x0 writes still handshake but never reach the register file.
  assign bus.rf_we_o        = (gnt != WB_GNT_NONE) && (addr != '0);
  assign bus.rf_addr_o      = addr;
  assign bus.rf_data_o      = data;
  assign bus.ex_ready_o     = (gnt == WB_GNT_EX);
  assign bus.ld_rsp_ready_o = (gnt == WB_GNT_LD);
  assign bus.ld_full_o      = q_full;

  // Built only from registered queue state: no path from ld_* inputs.
  always_comb begin
    sb = '0;
    for (int i = 0; i < LD_DEPTH; i++)
      if (ent_vld[i]) sb[tags[i]] = 1'b1;
    sb[0] = 1'b0;
  end
  assign bus.sb_pending_o = sb;

  a_no_raw_waw: assert property (@(posedge clk) disable iff (rst)
    !(gnt == WB_GNT_EX && sb[bus.ex_rd_addr_i]))
    else $error("EXEC write to register with a load in flight");
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if bus();
  wb_arbiter #(.LD_DEPTH(4), .MAX_LD_STREAK(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        rst;
    logic        exv;
    logic [4:0]  exrd;
    logic [31:0] exd;
    logic        iss;
    logic [4:0]  issrd;
    logic        rv;
    logic [31:0] rd;
    logic        e_exr;
    logic        e_ldr;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_full;
    logic [31:0] e_sb;
  } vec_t;

  vec_t vq[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic r, logic exv, logic [4:0] exrd, logic [31:0] exd,
                              logic iss, logic [4:0] issrd, logic rv, logic [31:0] rd,
                              logic e_exr, logic e_ldr, logic e_we, logic [4:0] e_addr,
                              logic [31:0] e_data, logic e_full, logic [31:0] e_sb);
    vec_t v;
    v.rst = r; v.exv = exv; v.exrd = exrd; v.exd = exd; v.iss = iss; v.issrd = issrd;
    v.rv = rv; v.rd = rd; v.e_exr = e_exr; v.e_ldr = e_ldr; v.e_we = e_we;
    v.e_addr = e_addr; v.e_data = e_data; v.e_full = e_full; v.e_sb = e_sb;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic exv, input logic [4:0] exrd, input logic [31:0] exd,
                       input logic iss, input logic [4:0] issrd, input logic rv, input logic [31:0] rd);
    rst = r;
    bus.ex_valid_i = exv;   bus.ex_rd_addr_i = exrd;   bus.ex_rd_data_i = exd;
    bus.ld_issue_i = iss;   bus.ld_issue_rd_i = issrd;
    bus.ld_rsp_valid_i = rv; bus.ld_rsp_data_i = rd;
  endtask

  // Expected grant per cycle of the starvation sequence (0=LD, 1=EX).
  int exp_g[6];
  int ld_acc;
  logic ex_done;

  initial begin
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    //      rst exv exrd exd    iss rd   rv data          exr ldr we addr data         full sb
    vq.push_back(mk(1, 1, 7, 32'h11, 0, 0, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'h0));
    vq.push_back(mk(1, 0, 0, 0,      0, 0, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'h0));
    // single load to x5, response three cycles later
    vq.push_back(mk(0, 0, 0, 0,      1, 5, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'h20));
    vq.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'h20));
    vq.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'hDEADBEEF, 0, 1, 1, 5, 32'hDEADBEEF, 0, 32'h20));
    vq.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'h0));
    // EX and LD collide: LD first, EX next cycle
    vq.push_back(mk(0, 0, 0, 0,      1, 3, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'h0));
    vq.push_back(mk(0, 1, 7, 32'h11, 0, 0, 1, 32'h22,      0, 1, 1, 3, 32'h22,       0, 32'h8));
    vq.push_back(mk(0, 1, 7, 32'h11, 0, 0, 0, 0,           1, 0, 1, 7, 32'h11,       0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'h0));
    // fill queue 1..4, then push 6 with a pop while full
    vq.push_back(mk(0, 0, 0, 0,      1, 1, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0,      1, 2, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'h2));
    vq.push_back(mk(0, 0, 0, 0,      1, 3, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'h6));
    vq.push_back(mk(0, 0, 0, 0,      1, 4, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'hE));
    vq.push_back(mk(0, 0, 0, 0,      1, 6, 1, 32'hA1,      0, 1, 1, 1, 32'hA1,       1, 32'h1E));
    vq.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0,           0, 0, 0, 0, 32'h0,        1, 32'h5C));
    vq.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'hB2,      0, 1, 1, 2, 32'hB2,       1, 32'h5C));
    vq.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'hB3,      0, 1, 1, 3, 32'hB3,       0, 32'h58));
    vq.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'hB4,      0, 1, 1, 4, 32'hB4,       0, 32'h50));
    vq.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'hB6,      0, 1, 1, 6, 32'hB6,       0, 32'h40));
    // response with an empty queue is never accepted
    vq.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'hEE,      0, 0, 0, 0, 32'h0,        0, 32'h0));
    // load to x0: handshake and pop, no write
    vq.push_back(mk(0, 0, 0, 0,      1, 0, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'h55,      0, 1, 0, 0, 32'h55,       0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'h66,      0, 0, 0, 0, 32'h0,        0, 32'h0));
    vq.push_back(mk(0, 1, 0, 32'h99, 0, 0, 0, 0,           1, 0, 0, 0, 32'h99,       0, 32'h0));
    // reset with two loads outstanding, then a late response
    vq.push_back(mk(0, 0, 0, 0,      1, 9, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'h0));
    vq.push_back(mk(0, 0, 0, 0,      1, 10, 0, 0,          0, 0, 0, 0, 32'h0,        0, 32'h200));
    vq.push_back(mk(1, 0, 0, 0,      0, 0, 0, 0,           0, 0, 0, 0, 32'h0,        0, 32'h600));
    vq.push_back(mk(0, 0, 0, 0,      0, 0, 1, 32'h77,      0, 0, 0, 0, 32'h0,        0, 32'h0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].exv, vq[i].exrd, vq[i].exd, vq[i].iss, vq[i].issrd, vq[i].rv, vq[i].rd);
      #1;
      chk("ex_ready", i, 32'(bus.ex_ready_o), 32'(vq[i].e_exr));
      chk("ld_rsp_ready", i, 32'(bus.ld_rsp_ready_o), 32'(vq[i].e_ldr));
      chk("rf_we", i, 32'(bus.rf_we_o), 32'(vq[i].e_we));
      chk("rf_addr", i, 32'(bus.rf_addr_o), 32'(vq[i].e_addr));
      chk("rf_data", i, bus.rf_data_o, vq[i].e_data);
      chk("ld_full", i, 32'(bus.ld_full_o), 32'(vq[i].e_full));
      chk("sb_pending", i, bus.sb_pending_o, vq[i].e_sb);
    end

    // Starvation: four loads queued, a fifth issued on the first response
    // cycle; EXEC (rd 20) waits throughout.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 5'(11 + k), 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("starve_full", 0, 32'(bus.ld_full_o), 32'd1);
`ifdef WB_STARVE_GUARD_EN
    exp_g = '{0, 0, 0, 1, 0, 0};
`else
    exp_g = '{0, 0, 0, 0, 0, 1};
`endif
    ld_acc = 0;
    ex_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(0, !ex_done, 5'd20, 32'hE0, c == 0, 5'd15, ld_acc < 5, 32'hC0 + 32'(ld_acc));
      #1;
      chk("starve_ld_ready", c, 32'(bus.ld_rsp_ready_o), 32'(exp_g[c] == 0));
      chk("starve_ex_ready", c, 32'(bus.ex_ready_o), 32'(exp_g[c] == 1));
      if (exp_g[c] == 0) begin
        chk("starve_addr", c, 32'(bus.rf_addr_o), 32'(11 + ld_acc));
        chk("starve_data", c, bus.rf_data_o, 32'hC0 + 32'(ld_acc));
        ld_acc++;
      end else begin
        chk("starve_addr", c, 32'(bus.rf_addr_o), 32'd20);
        chk("starve_data", c, bus.rf_data_o, 32'hE0);
        ex_done = 1'b1;
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("starve_sb_drained", 0, bus.sb_pending_o, 32'h0);
    chk("starve_not_full", 0, 32'(bus.ld_full_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
